// File: rtl/nvdla_pdp_wdma_pkg.sv
// nvdla_pdp_wdma_pkg: shared constants, FSM state type and lane-mask helper for the PDP WDMA data packer
package nvdla_pdp_wdma_pkg;
  localparam int ATOM_W = 64;
  localparam int PACK_NUM = 4;
  localparam int CNT_W = 13;
  localparam int MASK_W = PACK_NUM;
  localparam int DAT_W = ATOM_W * PACK_NUM;
  localparam int PCNT_W = $clog2(PACK_NUM);
  localparam int PERF_W = 32;
  localparam logic [PERF_W-1:0] PERF_SAT = '1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  function automatic logic [MASK_W-1:0] lane_mask(input logic [PCNT_W-1:0] top);
    logic [MASK_W-1:0] m;
    for (int k = 0; k < MASK_W; k++) m[k] = PCNT_W'(k) <= top;
    return m;
  endfunction
endpackage

// File: rtl/nvdla_pdp_wdma_dat_pack_if.sv
// nvdla_pdp_wdma_dat_pack_if: atom ingress and packed-beat egress handshakes of the WDMA data packer
interface nvdla_pdp_wdma_dat_pack_if;
  import nvdla_pdp_wdma_pkg::*;
  logic pdp_dp2wdma_valid;
  logic pdp_dp2wdma_ready;
  logic [ATOM_W-1:0] pdp_dp2wdma_pd;
  logic wr_dat_pvld;
  logic wr_dat_prdy;
  logic [DAT_W-1:0] wr_dat_pd;
  logic [MASK_W-1:0] wr_dat_mask;
  logic wr_dat_eol;
  logic wr_dat_last;
  modport slave (
    input pdp_dp2wdma_valid, pdp_dp2wdma_pd, wr_dat_prdy,
    output pdp_dp2wdma_ready, wr_dat_pvld, wr_dat_pd, wr_dat_mask, wr_dat_eol, wr_dat_last
  );
  modport master (
    output pdp_dp2wdma_valid, pdp_dp2wdma_pd, wr_dat_prdy,
    input pdp_dp2wdma_ready, wr_dat_pvld, wr_dat_pd, wr_dat_mask, wr_dat_eol, wr_dat_last
  );
endinterface

// File: rtl/nvdla_pdp_wdma_pos_cnt.sv
// nvdla_pdp_wdma_pos_cnt: w/h/surface position of the current atom within the output cube
module nvdla_pdp_wdma_pos_cnt
  import nvdla_pdp_wdma_pkg::*;
(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             load,
  input  logic             adv,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  input  logic [CNT_W-1:0] channel,
  output logic             is_eol,
  output logic             is_last
);
  logic [CNT_W-1:0] width_q, height_q, surf_q, w_cnt, h_cnt, s_cnt;
  logic is_eoh;
  assign is_eol = w_cnt == width_q;
  assign is_eoh = is_eol && h_cnt == height_q;
  assign is_last = is_eoh && s_cnt == surf_q;
  // surfaces hold 8 channels each, so the last surface index is channel/8
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      width_q <= '0;
      height_q <= '0;
      surf_q <= '0;
      w_cnt <= '0;
      h_cnt <= '0;
      s_cnt <= '0;
    end else if (load) begin
      width_q <= width;
      height_q <= height;
      surf_q <= channel >> 3;
      w_cnt <= '0;
      h_cnt <= '0;
      s_cnt <= '0;
    end else if (adv) begin
      w_cnt <= is_eol ? '0 : w_cnt + 1'b1;
      h_cnt <= is_eoh ? '0 : is_eol ? h_cnt + 1'b1 : h_cnt;
      s_cnt <= is_last ? '0 : is_eoh ? s_cnt + 1'b1 : s_cnt;
    end
  end
endmodule

// File: rtl/nvdla_pdp_wdma_dat_pack.sv
// nvdla_pdp_wdma_dat_pack: packs pooled 64-bit atoms into 256-bit WDMA write beats with eol/last flush.
// NVDLA_PDP_WDMA_PERF_EN builds the saturating output-stall counter; otherwise wdma_stall_cnt is tied to 0.
module nvdla_pdp_wdma_dat_pack
  import nvdla_pdp_wdma_pkg::*;
(
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     op_load,
  input  logic [CNT_W-1:0]         reg2dp_cube_out_width,
  input  logic [CNT_W-1:0]         reg2dp_cube_out_height,
  input  logic [CNT_W-1:0]         reg2dp_cube_out_channel,
  nvdla_pdp_wdma_dat_pack_if.slave dp,
  output logic                     wdma_dat_done,
  output logic [PERF_W-1:0]        wdma_stall_cnt
);
  state_e state_q, state_d;
  logic load, accept, close, drain_done, is_eol, is_last;
  logic [PCNT_W-1:0] pack_cnt;
  logic [PACK_NUM-1:0][ATOM_W-1:0] pack_q;
  logic [DAT_W-1:0] beat_d;
  assign load = op_load && state_q == IDLE;
  assign dp.pdp_dp2wdma_ready = state_q == RUN && (!dp.wr_dat_pvld || dp.wr_dat_prdy);
  assign accept = dp.pdp_dp2wdma_valid && dp.pdp_dp2wdma_ready;
  assign close = accept && (pack_cnt == PCNT_W'(PACK_NUM - 1) || is_eol);
  nvdla_pdp_wdma_pos_cnt u_pos (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .load           (load),
    .adv            (accept),
    .width          (reg2dp_cube_out_width),
    .height         (reg2dp_cube_out_height),
    .channel        (reg2dp_cube_out_channel),
    .is_eol         (is_eol),
    .is_last        (is_last)
  );
  always_comb begin
    drain_done = state_q == DRAIN && dp.wr_dat_pvld && dp.wr_dat_prdy;
    state_d = (state_q == IDLE && load) ? RUN :
              (state_q == RUN && accept && is_last) ? DRAIN :
              drain_done ? IDLE : state_q;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= IDLE;
      wdma_dat_done <= 1'b0;
    end else begin
      state_q <= state_d;
      wdma_dat_done <= drain_done;
    end
  end
  // lanes below pack_cnt come from the pack register, the incoming atom fills pack_cnt, the rest flush as 0
  always_comb begin
    beat_d = '0;
    for (int k = 0; k < PACK_NUM; k++)
      beat_d[k*ATOM_W +: ATOM_W] = (PCNT_W'(k) < pack_cnt) ? pack_q[k] :
                                   (PCNT_W'(k) == pack_cnt) ? dp.pdp_dp2wdma_pd : '0;
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pack_cnt <= '0;
      pack_q <= '0;
    end else if (load) begin
      pack_cnt <= '0;
    end else if (accept) begin
      pack_cnt <= close ? '0 : pack_cnt + 1'b1;
      if (!close) pack_q[pack_cnt] <= dp.pdp_dp2wdma_pd;
    end
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dp.wr_dat_pvld <= 1'b0;
      dp.wr_dat_pd <= '0;
      dp.wr_dat_mask <= '0;
      dp.wr_dat_eol <= 1'b0;
      dp.wr_dat_last <= 1'b0;
    end else begin
      dp.wr_dat_pvld <= close ? 1'b1 : dp.wr_dat_prdy ? 1'b0 : dp.wr_dat_pvld;
      if (close) begin
        dp.wr_dat_pd <= beat_d;
        dp.wr_dat_mask <= lane_mask(pack_cnt);
        dp.wr_dat_eol <= is_eol;
        dp.wr_dat_last <= is_last;
      end
    end
  end
`ifdef NVDLA_PDP_WDMA_PERF_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) wdma_stall_cnt <= '0;
    else if (load) wdma_stall_cnt <= '0;
    else if (dp.wr_dat_pvld && !dp.wr_dat_prdy && wdma_stall_cnt != PERF_SAT) wdma_stall_cnt <= wdma_stall_cnt + 1'b1;
  end
`else
  assign wdma_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_nvdla_pdp_wdma_dat_pack.sv
// tb_nvdla_pdp_wdma_dat_pack: table-driven cube runs with hand-computed beats, plus reset and stall sequences
module tb_nvdla_pdp_wdma_dat_pack;
  import nvdla_pdp_wdma_pkg::*;
  typedef struct {
    logic [3:0][7:0] ids;
    logic [3:0] mask;
    logic eol;
    logic last;
  } beat_t;
  typedef struct {
    logic [12:0] w, h, ch;
    int n_atoms, first, n_beats;
    bit stall, mid_load;
  } cube_t;
  logic clk = 0, rstn = 0, op_load = 0, done;
  logic [12:0] cfg_w = 0, cfg_h = 0, cfg_c = 0;
  logic [31:0] stall_cnt;
  int n_vec = 0, n_err = 0;
  beat_t exp_b[12];
  cube_t cubes[5];
  nvdla_pdp_wdma_dat_pack_if dp();
  nvdla_pdp_wdma_dat_pack dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .op_load(op_load),
    .reg2dp_cube_out_width(cfg_w), .reg2dp_cube_out_height(cfg_h), .reg2dp_cube_out_channel(cfg_c),
    .dp(dp), .wdma_dat_done(done), .wdma_stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] atom(input int i);
    logic [7:0] b = 8'(i);
    return {8{b}};
  endfunction
  function automatic beat_t mk(input int a0, a1, a2, a3, input logic [3:0] m, input logic e, l);
    beat_t b;
    b.ids = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    b.mask = m;
    b.eol = e;
    b.last = l;
    return b;
  endfunction
  function automatic logic [255:0] exp_pd(input beat_t b);
    logic [255:0] p;
    for (int k = 0; k < 4; k++) p[k*64 +: 64] = {8{b.ids[k]}};
    return p;
  endfunction
  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pvld"}, 264'(dp.wr_dat_pvld), 0);
    chk({tag, "_pd"}, 264'(dp.wr_dat_pd), 0);
    chk({tag, "_mask"}, 264'(dp.wr_dat_mask), 0);
    chk({tag, "_eol_last"}, 264'({dp.wr_dat_eol, dp.wr_dat_last}), 0);
    chk({tag, "_ready"}, 264'(dp.pdp_dp2wdma_ready), 0);
    chk({tag, "_done"}, 264'(done), 0);
    chk({tag, "_stall_cnt"}, 264'(stall_cnt), 0);
  endtask
  task automatic run_cube(input cube_t c);
    int ai = 0, bi = 0, cyc = 0, stalls = 0;
    bit exp_done = 0, held = 0, finished = 0;
    logic [255:0] held_pd = '0;
    @(negedge clk);
    cfg_w = c.w; cfg_h = c.h; cfg_c = c.ch; op_load = 1;
    @(negedge clk);
    op_load = 0;
    while (cyc < 300) begin
      dp.wr_dat_prdy = c.stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      dp.pdp_dp2wdma_valid = ai < c.n_atoms;
      dp.pdp_dp2wdma_pd = atom(ai + 1);
      op_load = c.mid_load && cyc == 3;
      cfg_w = (c.mid_load && cyc == 3) ? 13'd0 : c.w;
      #1;
      if (exp_done) begin
        chk("done_pulse", 264'(done), 1);
        finished = 1;
        break;
      end
      if (done) chk("spurious_done", 264'(done), 0);
      if (held) chk("stall_hold_pd", 264'(dp.wr_dat_pd), 264'(held_pd));
      held = dp.wr_dat_pvld && !dp.wr_dat_prdy;
      held_pd = dp.wr_dat_pd;
      if (held) begin
        stalls++;
        chk("stall_ready_low", 264'(dp.pdp_dp2wdma_ready), 0);
      end
      if (dp.wr_dat_pvld && dp.wr_dat_prdy) begin
        if (bi < c.n_beats)
          chk($sformatf("beat%0d", c.first + bi),
              {2'b0, dp.wr_dat_pd, dp.wr_dat_mask, dp.wr_dat_eol, dp.wr_dat_last},
              {2'b0, exp_pd(exp_b[c.first + bi]), exp_b[c.first + bi].mask, exp_b[c.first + bi].eol, exp_b[c.first + bi].last});
        else chk("extra_beat", 264'(bi), 264'(c.n_beats));
        exp_done = bi == c.n_beats - 1;
        bi++;
      end
      if (dp.pdp_dp2wdma_valid && dp.pdp_dp2wdma_ready) ai++;
      @(negedge clk);
      cyc++;
    end
    dp.pdp_dp2wdma_valid = 0;
    op_load = 0;
    cfg_w = c.w;
    chk("cube_finished", 264'(finished), 1);
    chk("beats_seen", 264'(bi), 264'(c.n_beats));
    chk("atoms_taken", 264'(ai), 264'(c.n_atoms));
`ifdef NVDLA_PDP_WDMA_PERF_EN
    chk("stall_cnt", 264'(stall_cnt), 264'(stalls));
`else
    chk("stall_cnt", 264'(stall_cnt), 0);
`endif
  endtask
  initial begin
    exp_b[0] = mk(1, 2, 3, 4, 4'hF, 0, 0);
    exp_b[1] = mk(5, 6, 7, 8, 4'hF, 1, 1);
    exp_b[2] = mk(1, 2, 3, 4, 4'hF, 0, 0);
    exp_b[3] = mk(5, 6, 0, 0, 4'h3, 1, 0);
    exp_b[4] = mk(7, 8, 9, 10, 4'hF, 0, 0);
    exp_b[5] = mk(11, 12, 0, 0, 4'h3, 1, 1);
    for (int i = 0; i < 6; i++) exp_b[6 + i] = mk(i + 1, 0, 0, 0, 4'h1, 1, i == 5);
    cubes[0] = '{w: 7, h: 0, ch: 7, n_atoms: 8, first: 0, n_beats: 2, stall: 0, mid_load: 0};
    cubes[1] = '{w: 5, h: 1, ch: 0, n_atoms: 12, first: 2, n_beats: 4, stall: 0, mid_load: 0};
    cubes[2] = '{w: 7, h: 0, ch: 7, n_atoms: 8, first: 0, n_beats: 2, stall: 1, mid_load: 0};
    cubes[3] = '{w: 0, h: 2, ch: 15, n_atoms: 6, first: 6, n_beats: 6, stall: 0, mid_load: 0};
    cubes[4] = '{w: 7, h: 0, ch: 7, n_atoms: 8, first: 0, n_beats: 2, stall: 0, mid_load: 1};
    dp.pdp_dp2wdma_valid = 0;
    dp.pdp_dp2wdma_pd = '0;
    dp.wr_dat_prdy = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1;
    for (int i = 0; i < 5; i++) run_cube(cubes[i]);
    // load a cube, park one full beat behind a stalled output, then reset mid-operation
    @(negedge clk);
    cfg_w = 7; cfg_h = 0; cfg_c = 7; op_load = 1;
    @(negedge clk);
    op_load = 0;
    dp.wr_dat_prdy = 0;
    for (int a = 0; a < 5; a++) begin
      dp.pdp_dp2wdma_valid = 1;
      dp.pdp_dp2wdma_pd = atom(a + 1);
      @(negedge clk);
    end
    #1;
    chk("mid_beat_held", 264'(dp.wr_dat_pvld), 1);
    chk("mid_ready_low", 264'(dp.pdp_dp2wdma_ready), 0);
    rstn = 0;
    #1;
    chk_reset_outputs("midreset");
    dp.pdp_dp2wdma_valid = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_stale_done", 264'(done), 0);
    end
    run_cube(cubes[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
